lms_adapt_filt_ntap: RTL and testbench

- Parametrised N-tap LMS adaptive FIR filter. Successor to the fixed 4-tap LMS block.
- Uses one time-shared multiplier with a serial MAC, so it adds an input/output valid handshake.
- Supports run-time adaptation freeze and a coefficient preload port.
- Sits between the sample source (x, desired d) and the error/output consumers in the adaptive noise-cancel path.

---
 rtl/lms_adapt_filt_ntap.sv | 228 ++++++++++++++++++++++
 tb/tb_lms_adapt_filt_ntap.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/lms_adapt_filt_ntap.sv
`default_nettype none
// ============================================================================
// Module      : lms_adapt_filt_ntap
// Description : N-tap LMS adaptive FIR filter. One multiplier is time-shared
//               between the filter MAC and the coefficient update, so samples
//               are taken through a valid/ready handshake.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk           in   rising-edge clock
//   rst           in   synchronous active-high reset
//   in_valid      in   xin/din valid
//   in_ready      out  block can accept a sample (IDLE and not in reset)
//   xin           in   XW-bit signed input sample
//   din           in   DW-bit signed desired sample
//   adapt_en      in   latched at acceptance; 0 freezes weights for that sample
//   coef_wr_en    in   coefficient preload strobe (IDLE only, no coincident accept)
//   coef_wr_addr  in   tap index for preload
//   coef_wr_data  in   WW-bit signed Q1.(WW-1) coefficient
//   out_valid     out  one-cycle pulse, filt_out/errr valid
//   filt_out      out  DW-bit signed filter output y
//   errr          out  DW-bit signed error e = d - y
// Configuration macro
//   LMS_SIGN_ERR_EN : when defined, weights adapt with the sign of the error
//                     (multiplier-free update); otherwise standard LMS.
// ============================================================================
module lms_adapt_filt_ntap #(
  parameter int TAPS     = 4,
  parameter int XW       = 8,
  parameter int DW       = 10,
  parameter int WW       = 16,
  parameter int MU_SHIFT = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic signed [XW-1:0]      xin,
  input  logic signed [DW-1:0]      din,
  input  logic                      adapt_en,
  input  logic                      coef_wr_en,
  input  logic [$clog2(TAPS)-1:0]   coef_wr_addr,
  input  logic signed [WW-1:0]      coef_wr_data,
  output logic                      out_valid,
  output logic signed [DW-1:0]      filt_out,
  output logic signed [DW-1:0]      errr
);

  localparam int IW = $clog2(TAPS);
  localparam int AW = XW + WW + IW;           // accumulator, cannot overflow
  localparam int MW = (WW > DW) ? WW : DW;    // shared multiplier A operand
  localparam int PW = MW + XW;                // shared multiplier product
  localparam int SW = PW + 1;                 // coefficient update sum

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_MAC    = 2'd1;
  localparam logic [1:0] S_OUT    = 2'd2;
  localparam logic [1:0] S_UPDATE = 2'd3;

  localparam logic [IW-1:0] IDX_LAST = IW'(TAPS - 1);
  localparam logic [IW:0]   TAPS_C   = (IW + 1)'(TAPS);

  localparam logic signed [AW-1:0] Y_MAX = {{(AW-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [AW-1:0] Y_MIN = {{(AW-DW+1){1'b1}}, {(DW-1){1'b0}}};
  localparam logic signed [DW-1:0] E_MAX = {1'b0, {(DW-1){1'b1}}};
  localparam logic signed [DW-1:0] E_MIN = {1'b1, {(DW-1){1'b0}}};
  localparam logic signed [SW-1:0] W_MAX = {{(SW-WW+1){1'b0}}, {(WW-1){1'b1}}};
  localparam logic signed [SW-1:0] W_MIN = {{(SW-WW+1){1'b1}}, {(WW-1){1'b0}}};

  logic [1:0]              state_q, state_d;
  logic signed [XW-1:0]    x_q [TAPS];
  logic signed [XW-1:0]    x_d [TAPS];
  logic signed [WW-1:0]    h_q [TAPS];
  logic signed [WW-1:0]    h_d [TAPS];
  logic signed [AW-1:0]    acc_q, acc_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic signed [DW-1:0]    din_q, din_d;
  logic                    adapt_q, adapt_d;
  logic signed [DW-1:0]    filt_out_q, filt_out_d;
  logic signed [DW-1:0]    errr_q, errr_d;
  logic                    out_valid_q, out_valid_d;

  logic                    accept;
  logic signed [MW-1:0]    mul_a;
  logic signed [XW-1:0]    mul_b;
  logic signed [PW-1:0]    mul_p;
  logic signed [AW-1:0]    y_full;
  logic signed [DW-1:0]    y_sat;
  logic signed [DW:0]      e_diff;
  logic signed [DW-1:0]    e_sat;
  logic signed [SW-1:0]    step;
  logic signed [SW-1:0]    upd_sum;
  logic signed [WW-1:0]    h_new;
`ifdef LMS_SIGN_ERR_EN
  logic signed [WW:0]      x_aligned;
`endif

  // --------------------------------------------------------------------------
  // State and datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      x_q         <= '{default: '0};
      h_q         <= '{default: '0};
      acc_q       <= '0;
      idx_q       <= '0;
      din_q       <= '0;
      adapt_q     <= 1'b0;
      filt_out_q  <= '0;
      errr_q      <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      h_q         <= h_d;
      acc_q       <= acc_d;
      idx_q       <= idx_d;
      din_q       <= din_d;
      adapt_q     <= adapt_d;
      filt_out_q  <= filt_out_d;
      errr_q      <= errr_d;
      out_valid_q <= out_valid_d;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (accept) state_d = S_MAC;
      S_MAC:    if (idx_q == IDX_LAST) state_d = S_OUT;
      S_OUT:    state_d = adapt_q ? S_UPDATE : S_IDLE;
      S_UPDATE: if (idx_q == IDX_LAST) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath and outputs
  // --------------------------------------------------------------------------
  always_comb begin
    in_ready  = (state_q == S_IDLE) && !rst;
    accept    = in_valid && in_ready;
    out_valid = out_valid_q;
    filt_out  = filt_out_q;
    errr      = errr_q;

    // Shared multiplier: h*x while filtering, e*x while adapting.
    mul_b = x_q[idx_q];
`ifdef LMS_SIGN_ERR_EN
    mul_a = MW'(h_q[idx_q]);
`else
    mul_a = (state_q == S_UPDATE) ? MW'(errr_q) : MW'(h_q[idx_q]);
`endif
    mul_p = PW'(mul_a) * PW'(mul_b);

    // Output: floor-shift back to sample scale, then clamp.
    y_full = acc_q >>> (WW - 1);
    if (y_full > Y_MAX)      y_sat = Y_MAX[DW-1:0];
    else if (y_full < Y_MIN) y_sat = Y_MIN[DW-1:0];
    else                     y_sat = y_full[DW-1:0];

    // One guard bit is enough for d - y; overflow shows as top bits differing.
    e_diff = (DW + 1)'(din_q) - (DW + 1)'(y_sat);
    if (e_diff[DW] != e_diff[DW-1]) e_sat = e_diff[DW] ? E_MIN : E_MAX;
    else                            e_sat = e_diff[DW-1:0];

    // Coefficient update step for tap idx_q, based on the registered error.
`ifdef LMS_SIGN_ERR_EN
    x_aligned = (WW + 1)'(x_q[idx_q]) <<< (WW - XW);
    if (errr_q == '0)   step = '0;
    else if (errr_q[DW-1]) step = (-SW'(x_aligned)) >>> MU_SHIFT;
    else                step = SW'(x_aligned) >>> MU_SHIFT;
`else
    step = SW'(mul_p) >>> MU_SHIFT;
`endif
    upd_sum = SW'(h_q[idx_q]) + step;
    if (upd_sum > W_MAX)      h_new = W_MAX[WW-1:0];
    else if (upd_sum < W_MIN) h_new = W_MIN[WW-1:0];
    else                      h_new = upd_sum[WW-1:0];

    x_d         = x_q;
    h_d         = h_q;
    acc_d       = acc_q;
    idx_d       = idx_q;
    din_d       = din_q;
    adapt_d     = adapt_q;
    filt_out_d  = filt_out_q;
    errr_d      = errr_q;
    out_valid_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          x_d[0] = xin;
          for (int k = 1; k < TAPS; k++) x_d[k] = x_q[k-1];
          din_d   = din;
          adapt_d = adapt_en;
          acc_d   = '0;
          idx_d   = '0;
        end else if (coef_wr_en && ({1'b0, coef_wr_addr} < TAPS_C)) begin
          // A write colliding with an acceptance is dropped (else branch).
          h_d[coef_wr_addr] = coef_wr_data;
        end
      end
      S_MAC: begin
        acc_d = acc_q + AW'(mul_p);
        idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);
      end
      S_OUT: begin
        filt_out_d  = y_sat;
        errr_d      = e_sat;
        out_valid_d = 1'b1;
        idx_d       = '0;
      end
      S_UPDATE: begin
        h_d[idx_q] = h_new;
        idx_d      = (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);
      end
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_lms_adapt_filt_ntap.sv
`default_nettype none
// ============================================================================
// Module      : tb_lms_adapt_filt_ntap
// Description : Self-checking bench for lms_adapt_filt_ntap. An integer
//               reference model predicts y/e for each accepted sample and the
//               weights after adaptation; predictions go through a queue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lms_adapt_filt_ntap;

  localparam int TAPS     = 4;
  localparam int XW       = 8;
  localparam int DW       = 10;
  localparam int WW       = 16;
  localparam int MU_SHIFT = 8;

  logic                     clk = 1'b0;
  logic                     rst;
  logic                     in_valid;
  logic                     in_ready;
  logic signed [XW-1:0]     xin;
  logic signed [DW-1:0]     din;
  logic                     adapt_en;
  logic                     coef_wr_en;
  logic [$clog2(TAPS)-1:0]  coef_wr_addr;
  logic signed [WW-1:0]     coef_wr_data;
  logic                     out_valid;
  logic signed [DW-1:0]     filt_out;
  logic signed [DW-1:0]     errr;

  lms_adapt_filt_ntap #(
    .TAPS(TAPS), .XW(XW), .DW(DW), .WW(WW), .MU_SHIFT(MU_SHIFT)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .xin(xin), .din(din), .adapt_en(adapt_en),
    .coef_wr_en(coef_wr_en), .coef_wr_addr(coef_wr_addr), .coef_wr_data(coef_wr_data),
    .out_valid(out_valid), .filt_out(filt_out), .errr(errr)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  typedef struct { int y; int e; } exp_t;
  exp_t sb[$];

  int mx [TAPS];
  int mh [TAPS];

  function automatic int sat(longint v, int n);
    longint hi = (longint'(1) <<< (n - 1)) - 1;
    longint lo = -hi - 1;
    if (v > hi) return int'(hi);
    if (v < lo) return int'(lo);
    return int'(v);
  endfunction

  task automatic chk(string tag, logic signed [63:0] obs, logic signed [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < TAPS; k++) begin mx[k] = 0; mh[k] = 0; end
    sb.delete();
  endtask

  // Reference: shift, filter, error, optional adaptation.
  task automatic model_accept(int x, int d, bit a);
    longint acc = 0;
    exp_t   ex;
    int     s;
    for (int k = TAPS - 1; k > 0; k--) mx[k] = mx[k-1];
    mx[0] = x;
    for (int k = 0; k < TAPS; k++) acc += longint'(mh[k]) * mx[k];
    ex.y = sat(acc >>> (WW - 1), DW);
    ex.e = sat(longint'(d) - ex.y, DW);
    sb.push_back(ex);
    if (a) begin
      s = (ex.e > 0) ? 1 : (ex.e < 0) ? -1 : 0;
      for (int k = 0; k < TAPS; k++) begin
`ifdef LMS_SIGN_ERR_EN
        mh[k] = sat(mh[k] + ((longint'(s) * (longint'(mx[k]) <<< (WW - XW))) >>> MU_SHIFT), WW);
`else
        if (s == 2) mh[k] = 0; // unreachable; keeps s used in both builds
        mh[k] = sat(mh[k] + ((longint'(ex.e) * mx[k]) >>> MU_SHIFT), WW);
`endif
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    model_reset();
  endtask

  task automatic cwrite(int addr, int data);
    @(negedge clk);
    coef_wr_en   = 1'b1;
    coef_wr_addr = addr[$clog2(TAPS)-1:0];
    coef_wr_data = WW'(data);
    @(posedge clk); #1;
    coef_wr_en = 1'b0;
    if (addr < TAPS) mh[addr] = data;
  endtask

  task automatic check_w(string tag);
    for (int k = 0; k < TAPS; k++)
      chk($sformatf("%s_h%0d", tag, k), dut.h_q[k], mh[k]);
  endtask

  // Drive one sample; cw also strobes a coefficient write from the
  // acceptance cycle until the output pulse, all of which must be ignored.
  task automatic send(int x, int d, bit a, bit cw);
    int   n;
    exp_t ex;
    @(negedge clk);
    in_valid = 1'b1; xin = XW'(x); din = DW'(d); adapt_en = a;
    if (cw) begin coef_wr_en = 1'b1; coef_wr_addr = '0; coef_wr_data = 16'sh1234; end
    n = 0;
    while (!in_ready && n < 100) begin @(negedge clk); n++; end
    chk("accept_ready", in_ready, 1);
    model_accept(x, d, a);
    @(posedge clk); #1;
    in_valid = 1'b0; adapt_en = 1'b0;
    n = 0;
    while (!out_valid && n < 50) begin @(posedge clk); #1; n++; end
    coef_wr_en = 1'b0;
    chk("latency", n, TAPS + 1);
    ex = sb.pop_front();
    chk("filt_out", filt_out, ex.y);
    chk("errr", errr, ex.e);
    chk("ready_at_out", in_ready, a ? 0 : 1);
    @(posedge clk); #1;
    chk("out_valid_pulse", out_valid, 0);
    n = 1;
    while (!in_ready && n < 50) begin @(posedge clk); #1; n++; end
    chk("busy_cycles", n, a ? TAPS : 1);
  endtask

  initial begin
    int ov_seen;
    rst = 1'b1; in_valid = 1'b0; xin = '0; din = '0; adapt_en = 1'b0;
    coef_wr_en = 1'b0; coef_wr_addr = '0; coef_wr_data = '0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("ready_in_reset", in_ready, 0);
    rst = 1'b0;
    #1;
    chk("rst_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_filt_out", filt_out, 0);
    chk("rst_errr", errr, 0);

    // Zero weights, no adaptation.
    send(100, 50, 0, 0);
    chk("t1_y", filt_out, 0);
    chk("t1_e", errr, 50);
    check_w("t1");

    // Preloaded tap with adaptation, then a zero-error sample.
    do_reset();
    cwrite(0, 16384);
    send(100, 60, 1, 0);
    chk("t2_y", filt_out, 50);
    chk("t2_e", errr, 10);
`ifdef LMS_SIGN_ERR_EN
    chk("t2_h0", dut.h_q[0], 16484);
`else
    chk("t2_h0", dut.h_q[0], 16387);
`endif
    check_w("t2");
    send(100, 50, 1, 0);
    chk("t2b_e", errr, 0);
    check_w("t2b");

    // Output and error saturation.
    do_reset();
    for (int k = 0; k < TAPS; k++) cwrite(k, -32768);
    repeat (4) send(-128, -512, 0, 0);
    chk("t3_y_sat", filt_out, 511);
    chk("t3_e_sat", errr, -512);

    // Weight saturation, no wrap.
    do_reset();
    cwrite(0, 32767);
    send(127, 511, 1, 0);
    chk("t4_h0_sat", dut.h_q[0], 32767);
    check_w("t4");

    // Mixed samples, with ignored coefficient writes on some of them.
    do_reset();
    for (int k = 0; k < TAPS; k++) cwrite(k, int'($urandom_range(0, 16383)) - 8192);
    for (int i = 0; i < 8; i++) begin
      send(int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 1023)) - 512,
           bit'($urandom_range(0, 1)), (i % 3) == 0);
      check_w($sformatf("t5_%0d", i));
    end

    // Reset mid-MAC discards the sample.
    do_reset();
    cwrite(0, 16384);
    send(100, 60, 0, 0);
    @(negedge clk);
    in_valid = 1'b1; xin = 8'sd20; din = 10'sd5; adapt_en = 1'b1;
    chk("t6_ready", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0; adapt_en = 1'b0;
    @(posedge clk); #1;
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    model_reset();
    #1;
    chk("t6_ready_after", in_ready, 1);
    chk("t6_out_valid", out_valid, 0);
    chk("t6_filt_out", filt_out, 0);
    chk("t6_errr", errr, 0);
    check_w("t6");
    ov_seen = 0;
    repeat (12) begin @(posedge clk); #1; if (out_valid) ov_seen++; end
    chk("t6_no_pulse", ov_seen, 0);
    send(30, -7, 1, 0);
    check_w("t6b");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
